bit3_search_ctrl: RTL and testbench

- Sequential initiator that drives a 3-bit magnitude comparator. Finds an unknown 3-bit value by binary search.
- The unknown value sits on the comparator's a-inputs. This block drives the b-inputs (guess) and reads back gt/eq/lt.
- Used as the test/identification front end of the comparator datapath in the combinational lab set. It adds start/done control and error detection.

---
 rtl/bit3_search_ctrl.sv | 117 +++++++++++
 tb/tb_bit3_search_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit3_search_ctrl.sv
// Binary-search initiator for a 3-bit magnitude comparator: drives the guess on
// b2..b0, reads gt/eq/lt, and reports the identified value with error detection.
module bit3_search_ctrl #(
  parameter int SETTLE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gt,
  input  logic       eq,
  input  logic       lt,
  output logic       g2,
  output logic       g1,
  output logic       g0,
  output logic       busy,
  output logic       done,
  output logic       r2,
  output logic       r1,
  output logic       r0,
  output logic       err,
  output logic [2:0] steps
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROBE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [1:0]    state;
  logic [2:0]    lo, hi, guess, res;
  logic [CW-1:0] cnt;
  logic          busy_q, err_q;
  logic [2:0]    steps_q;

  logic [2:0] lo_n, hi_n, guess_n;
  logic       hit, fail, last_cycle;

  assign last_cycle = (cnt == CW'(SETTLE));

  // Outcome of the current probe and the bounds it would leave behind.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    lo_n = lo;
    hi_n = hi;
    hit  = 1'b0;
    fail = 1'b0;
    unique case ({gt, eq, lt})
      3'b010: hit = 1'b1;
      3'b100: if (guess == 3'd7) fail = 1'b1; else lo_n = guess + 3'd1;
      3'b001: if (guess == 3'd0) fail = 1'b1; else hi_n = guess - 3'd1;
      default: fail = 1'b1;
    endcase
    // Crossed bounds mean the unknown moved while we were searching.
    if (!hit && !fail && (lo_n > hi_n)) fail = 1'b1;
    guess_n = 3'(({1'b0, lo_n} + {1'b0, hi_n}) >> 1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lo      <= 3'd0;
      hi      <= 3'd7;
      guess   <= 3'd0;
      res     <= 3'd0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            lo      <= 3'd0;
            hi      <= 3'd7;
            guess   <= 3'd3;
            cnt     <= '0;
            steps_q <= 3'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state   <= PROBE;
          end
        end
        PROBE: begin
          if (last_cycle) begin
            steps_q <= steps_q + 3'd1;
            if (hit || fail) begin
              res    <= guess;
              err_q  <= fail;
              busy_q <= 1'b0;
              state  <= DONE;
            end else begin
              lo    <= lo_n;
              hi    <= hi_n;
              guess <= guess_n;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign {g2, g1, g0} = guess;
  assign {r2, r1, r0} = res;
  assign busy  = busy_q;
  assign done  = (state == DONE);
  assign err   = err_q;
  assign steps = steps_q;

endmodule

// File: tb/tb_bit3_search_ctrl.sv
// Scoreboard bench for bit3_search_ctrl: two instances (SETTLE=0 and SETTLE=2)
// driven by an ideal comparator model with optional forced flags.
module tb_bit3_search_ctrl;

  typedef struct {
    logic [2:0] r;
    logic       err;
    int         steps;
    int         lat;
    int         e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: SETTLE=0
  logic       start0 = 1'b0, frc0 = 1'b0;
  logic [2:0] unk0 = 3'd0, fv0 = 3'd0, gs0;
  logic       gt0, eq0, lt0, g2_0, g1_0, g0_0, busy0, done0, r2_0, r1_0, r0_0, err0;
  logic [2:0] steps0;
  exp_t       q0[$];

  assign gs0 = {g2_0, g1_0, g0_0};
  assign gt0 = frc0 ? fv0[2] : (unk0 > gs0);
  assign eq0 = frc0 ? fv0[1] : (unk0 == gs0);
  assign lt0 = frc0 ? fv0[0] : (unk0 < gs0);

  bit3_search_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .gt(gt0), .eq(eq0), .lt(lt0),
    .g2(g2_0), .g1(g1_0), .g0(g0_0), .busy(busy0), .done(done0),
    .r2(r2_0), .r1(r1_0), .r0(r0_0), .err(err0), .steps(steps0)
  );

  // Instance 2: SETTLE=2, ideal comparator only
  logic       start2 = 1'b0;
  logic [2:0] unk2 = 3'd0, gs2;
  logic       gt2, eq2, lt2, g2_2, g1_2, g0_2, busy2, done2, r2_2, r1_2, r0_2, err2;
  logic [2:0] steps2;
  exp_t       q2[$];

  assign gs2 = {g2_2, g1_2, g0_2};
  assign gt2 = (unk2 > gs2);
  assign eq2 = (unk2 == gs2);
  assign lt2 = (unk2 < gs2);

  bit3_search_ctrl #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .gt(gt2), .eq(eq2), .lt(lt2),
    .g2(g2_2), .g1(g1_2), .g0(g0_2), .busy(busy2), .done(done2),
    .r2(r2_2), .r1(r1_2), .r0(r0_2), .err(err2), .steps(steps2)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done0) begin
      check("dut0 done has request", int'(q0.size() > 0), 1);
      if (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        check("dut0 r", {r2_0, r1_0, r0_0}, e.r);
        check("dut0 err", err0, e.err);
        check("dut0 steps", steps0, e.steps);
        check("dut0 latency", cyc - e.e0, e.lat);
        check("dut0 busy at done", busy0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      check("dut2 done has request", int'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        exp_t e;
        e = q2.pop_front();
        check("dut2 r", {r2_2, r1_2, r0_2}, e.r);
        check("dut2 err", err2, e.err);
        check("dut2 steps", steps2, e.steps);
        check("dut2 latency", cyc - e.e0, e.lat);
        check("dut2 busy at done", busy2, 0);
      end
    end
  end

  // Launch one search; returns just after the accepting edge.
  task automatic go(input int which, input logic [2:0] u, input logic [2:0] r,
                    input logic e, input int st);
    exp_t x;
    @(negedge clk);
    x.r = r;
    x.err = e;
    x.steps = st;
    x.e0 = cyc + 1;
    if (which == 0) begin
      unk0 = u;
      x.lat = st;
      start0 = 1'b1;
      q0.push_back(x);
    end else begin
      unk2 = u;
      x.lat = st * 3;
      start2 = 1'b1;
      q2.push_back(x);
    end
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    while (((which == 0) ? q0.size() : q2.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("search completes in time", (which == 0) ? q0.size() : q2.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    int   st_tab[8] = '{3, 2, 3, 1, 3, 2, 3, 4};

    #3;
    check("reset g", gs0, 0);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset r", {r2_0, r1_0, r0_0}, 0);
    check("reset err", err0, 0);
    check("reset steps", steps0, 0);
    check("reset dut2 g", gs2, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exhaustive success with an ideal comparator
    for (int u = 0; u < 8; u++) begin
      go(0, 3'(u), 3'(u), 1'b0, st_tab[u]);
      wait_done(0);
    end

    // SETTLE=2: unknown=7 takes four probes of three cycles each; unknown=0 three
    go(1, 3'd7, 3'd7, 1'b0, 4);
    wait_done(1);
    go(1, 3'd0, 3'd0, 1'b0, 3);
    wait_done(1);

    // Unknown drops from 7 to 0 after the first sample: probes 3,5,4 then bounds cross
    @(negedge clk);
    unk0 = 3'd7;
    x.r = 3'd4; x.err = 1'b1; x.steps = 3; x.lat = 3; x.e0 = cyc + 1;
    q0.push_back(x);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    @(posedge clk);
    #1 unk0 = 3'd0;
    wait_done(0);

    // Illegal flag combinations on the first probe
    frc0 = 1'b1;
    fv0 = 3'b101;
    go(0, 3'd2, 3'd3, 1'b1, 1);
    wait_done(0);
    fv0 = 3'b000;
    go(0, 3'd2, 3'd3, 1'b1, 1);
    wait_done(0);
    frc0 = 1'b0;

    // Second start while busy is ignored
    go(0, 3'd5, 3'd5, 1'b0, 2);
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done(0);
    repeat (4) @(negedge clk);

    // Asynchronous reset during the second probe
    go(0, 3'd5, 3'd5, 1'b0, 2);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("abort g", gs0, 0);
    check("abort busy", busy0, 0);
    check("abort done", done0, 0);
    check("abort r", {r2_0, r1_0, r0_0}, 0);
    check("abort err", err0, 0);
    check("abort steps", steps0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    go(0, 3'd6, 3'd6, 1'b0, 3);
    wait_done(0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
